// File: rtl/sdram_pattern_pkg.sv
// Shared types for the SDRAM pattern master:
// pattern modes, FSM states and the LFSR step.
package sdram_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ADDR  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_INCR  = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT,
        CMP,
        FINISH
    } state_e;

    localparam int LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS_DEF = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] taps
    );
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/sdram_pattern_master_if.sv
// Control and frame-memory bus bundle of the
// pattern master; master = engine, slave = environment.
interface sdram_pattern_master_if #(
    parameter int AW = 20,
    parameter int DW = 16,
    parameter int CW = 16
);
    logic          START;
    logic          ABORT;
    logic [1:0]    MODE;
    logic          VERIFY;
    logic [AW-1:0] BASE_ADDR;
    logic [AW-1:0] END_ADDR;
    logic [DW-1:0] SEED;
    logic          BUSY;
    logic          DONE;
    logic [CW-1:0] ERR_COUNT;
    logic [AW-1:0] FIRST_ERR_ADDR;
    logic [AW-1:0] ADDRESS;
    logic [DW-1:0] DATA_OUT;
    logic [DW-1:0] DATA_IN;
    logic          READn;
    logic          WRn;
    logic          WAITn;

    modport master (
        input  START, ABORT, MODE, VERIFY,
        input  BASE_ADDR, END_ADDR, SEED,
        input  DATA_IN, WAITn,
        output BUSY, DONE, ERR_COUNT, FIRST_ERR_ADDR,
        output ADDRESS, DATA_OUT, READn, WRn
    );

    modport slave (
        output START, ABORT, MODE, VERIFY,
        output BASE_ADDR, END_ADDR, SEED,
        output DATA_IN, WAITn,
        input  BUSY, DONE, ERR_COUNT, FIRST_ERR_ADDR,
        input  ADDRESS, DATA_OUT, READn, WRn
    );
endinterface

// File: rtl/sdram_pattern_gen.sv
// Pattern generator: holds the INCR/LFSR state and
// maps mode + address + state to the current word.
module sdram_pattern_gen
    import sdram_pattern_pkg::*;
#(
    parameter int            AW   = 20,
    parameter int            DW   = 16,
    parameter logic [DW-1:0] TAPS = 16'hB400
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          step_i,
    input  mode_e         mode_i,
    input  logic [DW-1:0] seed_i,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] word_o
);
    logic [DW-1:0]    state_q, state_d;
    logic [DW-1:0]    lfsr_nx;
    logic [DW+AW-1:0] addr_ext;
    logic             unused_addr;

    if (DW == LFSR_W) begin : g_pkg_lfsr
        assign lfsr_nx = lfsr_step(state_q, TAPS);
    end else begin : g_gen_lfsr
        assign lfsr_nx = {1'b0, state_q[DW-1:1]}
                       ^ (state_q[0] ? TAPS : '0);
    end

    // ADDR mode: low DW bits of the address, zero-extended
    assign addr_ext    = {{DW{1'b0}}, addr_i};
    assign unused_addr = ^addr_ext[DW+AW-1:DW];

    // Next pattern state: (re)seed or step per mode
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            if (mode_i == MODE_LFSR && seed_i == '0)
                state_d = '1;
            else
                state_d = seed_i;
        end else if (step_i) begin
            if (mode_i == MODE_INCR)
                state_d = state_q + 1'b1;
            else if (mode_i == MODE_LFSR)
                state_d = lfsr_nx;
        end
    end

    // Current word presented for the access at addr_i
    always_comb begin
        word_o = state_q;
        unique case (mode_i)
            MODE_ADDR:  word_o = addr_ext[DW-1:0];
            MODE_CONST: word_o = seed_i;
            MODE_INCR:  word_o = state_q;
            MODE_LFSR:  word_o = state_q;
            default:    word_o = state_q;
        endcase
    end

    // Pattern state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= '0;
        else       state_q <= state_d;
    end

endmodule

// File: rtl/sdram_pattern_master.sv
// Bus master that fills an address range with a pattern
// and optionally reads it back, counting mismatches.
module sdram_pattern_master
    import sdram_pattern_pkg::*;
#(
    parameter int            AW        = 20,
    parameter int            DW        = 16,
    parameter int            CW        = 16,
    parameter logic [DW-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic CLK,
    input  logic RST,
    sdram_pattern_master_if.master bus
);
    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic          verify_q, verify_d;
    logic          abort_q, abort_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] end_q, end_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] seed_q, seed_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          wrn_q, wrn_d;
    logic          rdn_q, rdn_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] err_q, err_d;
    logic [AW-1:0] ferr_q, ferr_d;
    logic          waitl_q;

    logic          gen_load, gen_step;
    mode_e         gen_mode;
    logic [DW-1:0] gen_seed, gen_word;
    logic          at_end;

    sdram_pattern_gen #(
        .AW   (AW),
        .DW   (DW),
        .TAPS (LFSR_TAPS)
    ) u_gen (
        .clk_i  (CLK),
        .rst_i  (RST),
        .load_i (gen_load),
        .step_i (gen_step),
        .mode_i (gen_mode),
        .seed_i (gen_seed),
        .addr_i (addr_q),
        .word_o (gen_word)
    );

    // A pending abort ends the pass like the last address
    assign at_end = (addr_q == end_q) || abort_q;

    // WAITn sampled half a cycle early for rising-edge use
    always_ff @(negedge CLK) begin
        if (RST) waitl_q <= 1'b0;
        else     waitl_q <= bus.WAITn;
    end

    // Next-state, bus strobes and result bookkeeping
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        verify_d = verify_q;
        abort_d  = abort_q;
        base_d   = base_q;
        end_d    = end_q;
        addr_d   = addr_q;
        seed_d   = seed_q;
        dout_d   = dout_q;
        rdata_d  = rdata_q;
        wrn_d    = wrn_q;
        rdn_d    = rdn_q;
        busy_d   = busy_q;
        err_d    = err_q;
        ferr_d   = ferr_q;
        gen_load = 1'b0;
        gen_step = 1'b0;
        gen_mode = mode_q;
        gen_seed = seed_q;

        if (busy_q && bus.ABORT)
            abort_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    mode_d   = mode_e'(bus.MODE);
                    verify_d = bus.VERIFY;
                    base_d   = bus.BASE_ADDR;
                    end_d    = bus.END_ADDR;
                    seed_d   = bus.SEED;
                    abort_d  = 1'b0;
                    err_d    = '0;
                    ferr_d   = '0;
                    addr_d   = bus.BASE_ADDR;
                    gen_mode = mode_e'(bus.MODE);
                    gen_seed = bus.SEED;
                    gen_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                dout_d  = gen_word;
                wrn_d   = 1'b0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (waitl_q) begin
                    wrn_d = 1'b1;
                    if (at_end) begin
                        if (verify_q && !abort_q) begin
                            addr_d   = base_q;
                            gen_load = 1'b1;
                            state_d  = RD_ISSUE;
                        end else begin
                            state_d = FINISH;
                        end
                    end else begin
                        addr_d   = addr_q + 1'b1;
                        gen_step = 1'b1;
                        state_d  = WR_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                rdn_d   = 1'b0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (waitl_q) begin
                    rdata_d = bus.DATA_IN;
                    rdn_d   = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (rdata_q != gen_word) begin
                    if (err_q != {CW{1'b1}})
                        err_d = err_q + 1'b1;
                    if (err_q == '0)
                        ferr_d = addr_q;
                end
                if (at_end) begin
                    state_d = FINISH;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    gen_step = 1'b1;
                    state_d  = RD_ISSUE;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            mode_q   <= MODE_ADDR;
            verify_q <= 1'b0;
            abort_q  <= 1'b0;
            base_q   <= '0;
            end_q    <= '0;
            addr_q   <= '0;
            seed_q   <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
            wrn_q    <= 1'b1;
            rdn_q    <= 1'b1;
            busy_q   <= 1'b0;
            err_q    <= '0;
            ferr_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            verify_q <= verify_d;
            abort_q  <= abort_d;
            base_q   <= base_d;
            end_q    <= end_d;
            addr_q   <= addr_d;
            seed_q   <= seed_d;
            dout_q   <= dout_d;
            rdata_q  <= rdata_d;
            wrn_q    <= wrn_d;
            rdn_q    <= rdn_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
        end
    end

    assign bus.BUSY           = busy_q;
    assign bus.DONE           = (state_q == FINISH);
    assign bus.ERR_COUNT      = err_q;
    assign bus.FIRST_ERR_ADDR = ferr_q;
    assign bus.ADDRESS        = addr_q;
    assign bus.DATA_OUT       = dout_q;
    assign bus.READn          = rdn_q;
    assign bus.WRn            = wrn_q;

endmodule

// File: tb/tb_sdram_pattern_master.sv
// Directed bench for sdram_pattern_master: vector table
// of full runs plus abort and mid-access reset sequences.
module tb_sdram_pattern_master;

    typedef struct {
        logic [1:0]        mode;
        logic              verify;
        logic [19:0]       base;
        logic [19:0]       last;
        logic [15:0]       seed;
        int                waitc;
        logic              cor_en;
        logic [19:0]       cor_addr;
        int                nwr;
        int                nrd;
        logic [0:3][15:0]  d;
        int                err;
        logic [19:0]       ferr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sdram_pattern_master_if #(.AW(20), .DW(16), .CW(16)) bus ();

    sdram_pattern_master dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [logic [19:0]];
    logic [19:0] wa [$];
    logic [15:0] wd [$];
    int          nrd      = 0;
    int          low_cnt  = 0;
    int          done_cnt = 0;
    int          acc_cnt  = 0;
    int          waitc    = 0;
    logic        hold     = 1'b0;
    logic        waitl_tb = 1'b0;
    logic        cor_en   = 1'b0;
    logic [19:0] cor_addr = '0;

    vec_t vecs [7];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [19:0] a);
        logic [15:0] w;
        w = mem.exists(a) ? mem[a] : 16'h0000;
        if (cor_en && a == cor_addr) w = w ^ 16'h0040;
        return w;
    endfunction

    // Slave side: WAITn rises once the strobe has been low
    // for more than waitc cycles unless held off.
    always @(posedge clk) begin
        #1;
        if (!bus.WRn || !bus.READn) acc_cnt = acc_cnt + 1;
        else                        acc_cnt = 0;
        bus.WAITn = !hold && (acc_cnt > waitc);
    end

    always @(negedge clk) begin
        waitl_tb    = bus.WAITn;
        bus.DATA_IN = rd_word(bus.ADDRESS);
        if (!bus.WRn || !bus.READn) low_cnt = low_cnt + 1;
    end

    always @(posedge clk) begin
        if (!rst && !bus.WRn && waitl_tb) begin
            wa.push_back(bus.ADDRESS);
            wd.push_back(bus.DATA_OUT);
            mem[bus.ADDRESS] = bus.DATA_OUT;
        end
        if (!rst && !bus.READn && waitl_tb) nrd = nrd + 1;
        if (bus.DONE) done_cnt = done_cnt + 1;
    end

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        nrd     = 0;
        low_cnt = 0;
    endtask

    task automatic start_run(input logic [1:0] mode,
                             input logic verify,
                             input logic [19:0] base,
                             input logic [19:0] last,
                             input logic [15:0] seed,
                             input string nm);
        @(negedge clk);
        clear_logs();
        bus.MODE      = mode;
        bus.VERIFY    = verify;
        bus.BASE_ADDR = base;
        bus.END_ADDR  = last;
        bus.SEED      = seed;
        bus.START     = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        chk({nm, " busy"}, bus.BUSY, 1);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int b;
        int i;
        b = done_cnt;
        i = 0;
        while (done_cnt == b && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({nm, " done"}, done_cnt != b, 1);
        repeat (4) @(negedge clk);
        chk({nm, " pulses"}, done_cnt - b, 1);
        chk({nm, " busy_after"}, bus.BUSY, 0);
    endtask

    task automatic run_vec(input int k);
        vec_t  v;
        string nm;
        v        = vecs[k];
        nm       = $sformatf("v%0d", k);
        waitc    = v.waitc;
        cor_en   = v.cor_en;
        cor_addr = v.cor_addr;
        start_run(v.mode, v.verify, v.base, v.last, v.seed, nm);
        wait_done(2000, nm);
        chk({nm, " nwr"}, wa.size(), v.nwr);
        chk({nm, " nrd"}, nrd, v.nrd);
        for (int j = 0; j < 4; j++) begin
            if (j < v.nwr)
                chk($sformatf("%s d%0d", nm, j),
                    (j < wd.size()) ? wd[j] : 16'hxxxx, v.d[j]);
        end
        chk({nm, " a_first"}, (wa.size() > 0) ? wa[0] : 20'hx, v.base);
        chk({nm, " a_last"}, (wa.size() > 0) ? wa[$] : 20'hx, v.last);
        chk({nm, " err"}, bus.ERR_COUNT, v.err);
        chk({nm, " ferr"}, bus.FIRST_ERR_ADDR, v.ferr);
        chk({nm, " low"}, low_cnt, (v.nwr + v.nrd) * (v.waitc + 1));
        cor_en = 1'b0;
    endtask

    initial begin
        int i;

        vecs[0] = '{2'd1, 1'b0, 20'h00100, 20'h00103, 16'hA5A5,
                    0, 1'b0, 20'h0, 4, 0,
                    {16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5},
                    0, 20'h0};
        vecs[1] = '{2'd2, 1'b0, 20'hFFFFE, 20'h00001, 16'hFFFE,
                    0, 1'b0, 20'h0, 4, 0,
                    {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001},
                    0, 20'h0};
        vecs[2] = '{2'd3, 1'b1, 20'h00300, 20'h0030F, 16'h0001,
                    3, 1'b0, 20'h0, 16, 16,
                    {16'h0001, 16'hB400, 16'h5A00, 16'h2D00},
                    0, 20'h0};
        vecs[3] = '{2'd0, 1'b1, 20'h00200, 20'h0020F, 16'h0000,
                    0, 1'b1, 20'h00205, 16, 16,
                    {16'h0200, 16'h0201, 16'h0202, 16'h0203},
                    1, 20'h00205};
        vecs[4] = '{2'd3, 1'b1, 20'h00050, 20'h00050, 16'h0000,
                    1, 1'b0, 20'h0, 1, 1,
                    {16'hFFFF, 16'h0, 16'h0, 16'h0},
                    0, 20'h0};
        vecs[5] = '{2'd3, 1'b0, 20'h00060, 20'h00063, 16'h0000,
                    0, 1'b0, 20'h0, 4, 0,
                    {16'hFFFF, 16'hCBFF, 16'hD1FF, 16'hDCFF},
                    0, 20'h0};
        vecs[6] = '{2'd2, 1'b1, 20'h0000E, 20'h00011, 16'h1234,
                    2, 1'b1, 20'h00010, 4, 4,
                    {16'h1234, 16'h1235, 16'h1236, 16'h1237},
                    1, 20'h00010};

        bus.START     = 1'b0;
        bus.ABORT     = 1'b0;
        bus.MODE      = 2'd0;
        bus.VERIFY    = 1'b0;
        bus.BASE_ADDR = '0;
        bus.END_ADDR  = '0;
        bus.SEED      = '0;
        bus.DATA_IN   = '0;
        bus.WAITn     = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst ADDRESS", bus.ADDRESS, 0);
        chk("rst DATA_OUT", bus.DATA_OUT, 0);
        chk("rst WRn", bus.WRn, 1);
        chk("rst READn", bus.READn, 1);
        chk("rst BUSY", bus.BUSY, 0);
        chk("rst DONE", bus.DONE, 0);
        chk("rst ERR", bus.ERR_COUNT, 0);
        chk("rst FERR", bus.FIRST_ERR_ADDR, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) run_vec(k);

        // Abort during a stalled 3rd write; a START while
        // busy must be ignored.
        waitc = 3;
        start_run(2'd1, 1'b1, 20'h00400, 20'h0040F, 16'h5555, "abort");
        i = 0;
        while (wa.size() < 2 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("abort reach3", wa.size(), 2);
        hold = 1'b1;
        @(negedge clk);
        bus.ABORT     = 1'b1;
        bus.START     = 1'b1;
        bus.BASE_ADDR = 20'h00777;
        @(negedge clk);
        bus.ABORT = 1'b0;
        bus.START = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort WRn_held", bus.WRn, 0);
        chk("abort nwr_stall", wa.size(), 2);
        hold = 1'b0;
        wait_done(200, "abort");
        chk("abort nwr", wa.size(), 3);
        chk("abort nrd", nrd, 0);
        chk("abort a3", (wa.size() > 2) ? wa[2] : 20'hx, 20'h00402);

        // Reset while a write is stalled in WR_WAIT
        waitc = 0;
        hold  = 1'b1;
        start_run(2'd1, 1'b0, 20'h00500, 20'h0050F, 16'h1111, "rstw");
        i = 0;
        while (bus.WRn && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk("rstw WRn_low", bus.WRn, 0);
        i = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstw WRn", bus.WRn, 1);
        chk("rstw BUSY", bus.BUSY, 0);
        chk("rstw ADDRESS", bus.ADDRESS, 0);
        @(negedge clk);
        rst  = 1'b0;
        hold = 1'b0;
        repeat (6) @(negedge clk);
        chk("rstw no_done", done_cnt - i, 0);
        start_run(2'd1, 1'b0, 20'h00010, 20'h00011, 16'h00FF, "fresh");
        wait_done(200, "fresh");
        chk("fresh nwr", wa.size(), 2);
        chk("fresh d0", (wd.size() > 0) ? wd[0] : 16'hx, 16'h00FF);
        chk("fresh a1", (wa.size() > 1) ? wa[1] : 20'hx, 20'h00011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_pattern_master.md
Name: sdram_pattern_master

Overview:
- Parametrised successor of the single-mode fill CPU: a bus master that writes a programmable data pattern over an inclusive address range, then optionally reads the range back and checks it.
- Sits on the same 20-bit word-addressed SDRAM/SVGA frame-memory bus (ADDRESS/DATA/READn/WRn/WAITn) as a test/initialisation engine. It replaces the hard-wired fill loop with a start/done control interface, a mode select and error reporting.

Parameters:
- AW, 20, address width (words).
- DW, 16, data width.
- CW, 16, error-counter width.
- LFSR_TAPS, 16'hB400, Galois LFSR feedback mask; width DW.

Ports:
- CLK  in  1  system clock; the single clock of the block.
- RST  in  1  synchronous reset, active-high.
- START  in  1  one-cycle pulse; latches config and begins run when idle.
- ABORT  in  1  ends the run after the current bus access completes.
- MODE  in  2  0=ADDR, 1=CONST, 2=INCR, 3=LFSR.
- VERIFY  in  1  adds a read-back/compare pass after the write pass.
- BASE_ADDR  in  AW  first address.
- END_ADDR  in  AW  last address, inclusive.
- SEED  in  DW  pattern seed/constant.
- BUSY  out  1  high while a run is active.
- DONE  out  1  one-cycle pulse at end of run (normal or aborted).
- ERR_COUNT  out  CW  mismatch count, saturating.
- FIRST_ERR_ADDR  out  AW  address of first mismatch.
- ADDRESS  out  AW  bus address.
- DATA_OUT  out  DW  bus write data.
- DATA_IN  in  DW  bus read data.
- READn  out  1  read strobe, active-low.
- WRn  out  1  write strobe, active-low.
- WAITn  in  1  bus ready; access completes when high.

Behaviour:
- Reset values: ADDRESS=0, DATA_OUT=0, READn=1, WRn=1, BUSY=0, DONE=0, ERR_COUNT=0, FIRST_ERR_ADDR=0, FSM=IDLE.
- Reset mid-access forces strobes high on that edge. No completion is signalled.
- WAITn is registered on the falling edge of CLK (WAITnL). All decisions use WAITnL at the rising edge.
- FSM states: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CMP, FINISH.
- IDLE:
  - On START, latch MODE, VERIFY, BASE, END and SEED, and clear ERR_COUNT and FIRST_ERR_ADDR.
  - Load ADDRESS=BASE and the pattern state from SEED. Set BUSY=1 and go to WR_ISSUE.
  - START while BUSY is ignored.
- WR_ISSUE: DATA_OUT<=pattern(ADDRESS, state); WRn<=0; go to WR_WAIT.
- WR_WAIT: hold strobe, address and data until WAITnL=1. Then WRn<=1 and advance:
  - If ADDRESS==END or abort is pending, go to RD_ISSUE with ADDRESS=BASE and the pattern re-seeded when VERIFY=1 and not aborted; otherwise go to FINISH.
  - Else ADDRESS<=ADDRESS+1 (mod 2^AW), step the pattern, and return to WR_ISSUE.
- Minimum 2 cycles per write access.
- RD_ISSUE: READn<=0. RD_WAIT: on WAITnL=1, capture DATA_IN, set READn<=1, go to CMP.
- CMP:
  - Compare the captured word with the regenerated expected word. On mismatch, ERR_COUNT++ (saturating at 2^CW-1).
  - If it is the first mismatch, FIRST_ERR_ADDR<=ADDRESS.
  - Then advance exactly as in WR_WAIT, ending in FINISH.
- FINISH: DONE=1 for one cycle, BUSY<=0, go to IDLE. ERR_COUNT and FIRST_ERR_ADDR hold until the next START.
- ABORT is latched into a pending flag at any time while BUSY. A strobe is never withdrawn before WAITnL.
- Patterns, where n is the word index from BASE:
  - ADDR: low DW bits of ADDRESS, zero-extended if AW<DW.
  - CONST: SEED.
  - INCR: SEED+n, mod 2^DW.
  - LFSR: Galois shift using LFSR_TAPS, one step per word; SEED=0 is replaced by all-ones.
- END<BASE wraps through 2^AW-1 to 0. BASE==END gives exactly one access per pass.

Decomposition:
- Package sdram_pattern_pkg: MODE encodings, FSM state enum, default LFSR taps, and an lfsr_step function.
- Sub-module sdram_pattern_gen (SEED load, step enable, MODE → current word). It is instantiated once and re-seeded for the verify pass.

Test Plan:
- MODE=CONST, SEED=16'hA5A5, BASE=0x100, END=0x103, WAITn=1 → 4 writes of A5A5 to 0x100..0x103, DONE 1 cycle, BUSY low after.
- MODE=INCR, SEED=0xFFFE, BASE=0xFFFFE, END=0x00001 → writes FFFE,FFFF,0000,0001 at 0xFFFFE,0xFFFFF,0x00000,0x00001 (address and data wrap).
- MODE=LFSR, VERIFY=1, model memory returns written data, WAITn low 3 cycles per access → ERR_COUNT=0; WRn/READn held low through every wait.
- MODE=ADDR, VERIFY=1, memory corrupts the word at 0x205 (range 0x200..0x20F) → ERR_COUNT=1, FIRST_ERR_ADDR=0x205.
- ABORT pulsed during the 3rd write with WAITn low → the 3rd write completes when WAITn rises, no read pass, DONE pulses, 3 writes total.
- RST asserted in WR_WAIT → WRn=1, BUSY=0, ADDRESS=0 next edge, no DONE; a fresh START runs normally.
